param_lifo: RTL

PARAM_LIFO -- requirements
Module: param_lifo

---
 rtl/param_lifo.sv | 103 ++++++++++
 1 files changed

// File: rtl/param_lifo.sv
// param_lifo: parameterised LIFO stack with registered pop data, replace-top and pass-through.
// Optional sticky overflow/underflow flags are compiled in by defining PARAM_LIFO_ERR_FLAGS_EN.
module param_lifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] din,
    input  logic             push,
    input  logic             pop,
    input  logic             err_clr,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             ovf,
    output logic             unf
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             vld_q, vld_d;
    logic [AW-1:0]    wr_idx, top_idx;
    logic             do_push, do_pop, do_rep, do_pass;

    assign full        = count_q == CW'(DEPTH);
    assign empty       = count_q == '0;
    assign almost_full = count_q >= CW'(AF_LEVEL);
    assign count       = count_q;
    assign dout        = dout_q;
    assign dout_vld    = vld_q;

    // Slot above the top is the push target; the top slot feeds pops and replace-top writes.
    assign wr_idx  = AW'(count_q);
    assign top_idx = AW'(count_q - CW'(1));

    assign do_push = push & ~pop & ~full;
    assign do_pop  = pop & ~push & ~empty;
    assign do_rep  = push & pop & ~empty;
    assign do_pass = push & pop & empty;

    // Next occupancy and pop data; a simultaneous push+pop never changes the count.
    always_comb begin
        count_d = do_push ? count_q + CW'(1) : do_pop ? count_q - CW'(1) : count_q;
        dout_d  = do_pass ? din : (do_pop | do_rep) ? mem_q[top_idx] : dout_q;
        vld_d   = do_pop | do_rep | do_pass;
    end

    // Occupancy and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count_q <= '0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
        end
    end

    // Storage is not reset; entries become visible only after being written again.
    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wr_idx] <= din;
        else if (do_rep)
            mem_q[top_idx] <= din;
    end

`ifdef PARAM_LIFO_ERR_FLAGS_EN
    logic ovf_q, unf_q, ovf_evt, unf_evt;

    assign ovf_evt = push & ~pop & full;
    assign unf_evt = pop & ~push & empty;
    assign ovf     = ovf_q;
    assign unf     = unf_q;

    // Sticky error flags; a new event in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_evt | (ovf_q & ~err_clr);
            unf_q <= unf_evt | (unf_q & ~err_clr);
        end
    end
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign ovf            = 1'b0;
    assign unf            = 1'b0;
`endif

endmodule
